// File: rtl/inst_fetch_rom.sv
// Parametrised instruction ROM with a valid/ready fetch port, a 2-entry output buffer, relocation and fault reporting.
// Optional build macro INST_FETCH_ROM_BYTESWAP_EN byte-reverses every returned word (including NOP_WORD).
module inst_fetch_rom #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DATA_WIDTH  = 32,
  parameter int          FETCH_WORDS = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter logic [31:0] NOP_WORD    = 32'h00000000,
  // Program image as a packed vector, ROM word 0 in the least significant DATA_WIDTH bits.
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INIT_PROGRAM = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [31:0]                     req_addr,
  input  logic                            flush,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [FETCH_WORDS*DATA_WIDTH-1:0] rsp_data,
  output logic [31:0]                     rsp_addr,
  output logic                            rsp_fault
);

  localparam int          BPW        = DATA_WIDTH / 8;
  localparam int          BYTE_SHIFT = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int          RSP_WIDTH  = FETCH_WORDS * DATA_WIDTH;
  localparam logic [31:0] ALIGN_MASK = 32'(BPW - 1);
  localparam logic [32:0] ROM_DEPTH  = 33'd1 << ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] fit_nop();
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      if (b < 32) begin
        r[b] = NOP_WORD[b];
      end else begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction

  localparam logic [DATA_WIDTH-1:0] NOP_FIT = fit_nop();

  function automatic logic [DATA_WIDTH-1:0] rom_read(input logic [ADDR_WIDTH-1:0] idx);
    return INIT_PROGRAM[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

`ifdef INST_FETCH_ROM_BYTESWAP_EN
  function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int j = 0; j < BPW; j++) begin
      r[j*8 +: 8] = w[(BPW-1-j)*8 +: 8];
    end
    return r;
  endfunction
`endif

  logic                  out_valid_r;
  logic [RSP_WIDTH-1:0]  out_data_r;
  logic [31:0]           out_addr_r;
  logic                  out_fault_r;
  logic                  skd_valid_r;
  logic [RSP_WIDTH-1:0]  skd_data_r;
  logic [31:0]           skd_addr_r;
  logic                  skd_fault_r;

  logic                  accept_s;
  logic                  out_free_s;
  logic [31:0]           offset_s;
  logic [31:0]           word_idx_s;
  logic                  misaligned_s;
  logic [32:0]           word_k_s [FETCH_WORDS];
  logic [DATA_WIDTH-1:0] lane_s   [FETCH_WORDS];
  logic [RSP_WIDTH-1:0]  new_data_s;
  logic                  new_fault_s;

  // Ready depends only on state and reset, never on req_valid.
  assign req_ready  = reset && !skd_valid_r;
  assign accept_s   = req_valid && req_ready;
  assign out_free_s = !out_valid_r || rsp_ready;

  assign rsp_valid = out_valid_r;
  assign rsp_data  = out_data_r;
  assign rsp_addr  = out_addr_r;
  assign rsp_fault = out_fault_r;

  // Address decode and ROM read; index arithmetic is 33 bits so i+k never wraps into range.
  always_comb begin
    offset_s     = req_addr - BASE_ADDR;
    word_idx_s   = offset_s >> BYTE_SHIFT;
    misaligned_s = (req_addr & ALIGN_MASK) != 32'd0;
    new_fault_s  = misaligned_s;
    new_data_s   = '0;
    for (int k = 0; k < FETCH_WORDS; k++) begin
      word_k_s[k] = {1'b0, word_idx_s} + 33'(k);
      if (misaligned_s || (word_k_s[k] >= ROM_DEPTH)) begin
        lane_s[k]   = NOP_FIT;
        new_fault_s = 1'b1;
      end else begin
        lane_s[k]   = rom_read(word_k_s[k][ADDR_WIDTH-1:0]);
      end
`ifdef INST_FETCH_ROM_BYTESWAP_EN
      new_data_s[k*DATA_WIDTH +: DATA_WIDTH] = byte_swap(lane_s[k]);
`else
      new_data_s[k*DATA_WIDTH +: DATA_WIDTH] = lane_s[k];
`endif
    end
  end

  // Output/skid buffer: flush drops both entries but keeps a request accepted on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_addr_r  <= 32'd0;
      out_fault_r <= 1'b0;
      skd_valid_r <= 1'b0;
      skd_data_r  <= '0;
      skd_addr_r  <= 32'd0;
      skd_fault_r <= 1'b0;
    end else if (flush) begin
      skd_valid_r <= 1'b0;
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_data_r  <= new_data_s;
        out_addr_r  <= req_addr;
        out_fault_r <= new_fault_s;
      end
    end else if (out_free_s) begin
      if (skd_valid_r) begin
        out_valid_r <= 1'b1;
        out_data_r  <= skd_data_r;
        out_addr_r  <= skd_addr_r;
        out_fault_r <= skd_fault_r;
        skd_valid_r <= accept_s;
        if (accept_s) begin
          skd_data_r  <= new_data_s;
          skd_addr_r  <= req_addr;
          skd_fault_r <= new_fault_s;
        end
      end else if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= new_data_s;
        out_addr_r  <= req_addr;
        out_fault_r <= new_fault_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      skd_valid_r <= 1'b1;
      skd_data_r  <= new_data_s;
      skd_addr_r  <= req_addr;
      skd_fault_r <= new_fault_s;
    end
  end

endmodule
